triaram_reader: RTL and testbench

// - Read-side engine for the waveform RAM that the write datapath fills. Runs a phase accumulator and issues RAM read addresses and enables.
// - Aligns the returned RAM data with a pipelined valid and presents it as a sample stream to the DAC output stage.
// - Start/Stop control with a drain phase, so no in-flight read is lost.

---
 rtl/triaram_reader.sv | 141 ++++++++++++++
 tb/tb_triaram_reader.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/triaram_reader.sv
// Read-side engine for the waveform RAM: phase accumulator, read issue, and data/valid alignment.
// Optional build macro TRIARAM_RD_MIRROR_EN: half-period table with mirrored second half.
module triaram_reader #(
  parameter int AW     = 10,
  parameter int DW     = 16,
  parameter int PW     = 32,
  parameter int RD_LAT = 2
) (
  input  logic          Clock_i,
  input  logic          Reset_n_i,
  input  logic          Start_i,
  input  logic          Stop_i,
  input  logic [PW-1:0] Tuning_i,
  output logic [AW-1:0] RamAddr_o,
  output logic          RamEn_o,
  input  logic [DW-1:0] RamData_i,
  output logic [DW-1:0] Dout_o,
  output logic          DoutValid_o,
  output logic          Busy_o,
  output logic          Wrap_o
);

  localparam int CW = $clog2(RD_LAT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   phase_q, phase_d;
  logic [AW-1:0]   ramAddr_q, ramAddr_d;
  logic            ramEn_q, ramEn_d;
  logic            wrap_q, wrap_d;
  logic            busy_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [RD_LAT-1:0] enPipe_q;
  logic [DW-1:0]   dout_q;
  logic            doutValid_q;

  logic [PW:0]     sum;
  logic [AW-1:0]   tableAddr;

  assign sum = {1'b0, phase_q} + {1'b0, Tuning_i};

`ifdef TRIARAM_RD_MIRROR_EN
  // Second half of the period walks the half-table backwards.
  assign tableAddr = phase_q[PW-1] ? ~phase_q[PW-2:PW-AW-1] : phase_q[PW-2:PW-AW-1];
`else
  assign tableAddr = phase_q[PW-1:PW-AW];
`endif

  always_ff @(posedge Clock_i or negedge Reset_n_i) begin
    if (!Reset_n_i) begin
      state_q   <= IDLE;
      phase_q   <= '0;
      ramAddr_q <= '0;
      ramEn_q   <= 1'b0;
      wrap_q    <= 1'b0;
      busy_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      ramAddr_q <= ramAddr_d;
      ramEn_q   <= ramEn_d;
      wrap_q    <= wrap_d;
      busy_q    <= (state_d != IDLE);
      cnt_q     <= cnt_d;
    end
  end

  // Stop takes priority over Start in every state; Start while running restarts phase without a gap.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    ramAddr_d = ramAddr_q;
    ramEn_d   = 1'b0;
    wrap_d    = 1'b0;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE: begin
        if (Start_i && !Stop_i) begin
          state_d = RUN;
          phase_d = '0;
        end
      end
      RUN: begin
        if (Stop_i) begin
          state_d = DRAIN;
          cnt_d   = CW'(RD_LAT);
        end else begin
          ramEn_d   = 1'b1;
          ramAddr_d = tableAddr;
          if (Start_i) begin
            phase_d = '0;
          end else begin
            phase_d = sum[PW-1:0];
            wrap_d  = sum[PW];
          end
        end
      end
      DRAIN: begin
        if (cnt_q <= CW'(1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Read enables travel alongside the RAM latency so each returned word is tagged valid.
  always_ff @(posedge Clock_i or negedge Reset_n_i) begin
    if (!Reset_n_i) begin
      enPipe_q    <= '0;
      dout_q      <= '0;
      doutValid_q <= 1'b0;
    end else begin
      enPipe_q[0] <= ramEn_q;
      for (int i = 1; i < RD_LAT; i++) begin
        enPipe_q[i] <= enPipe_q[i-1];
      end
      doutValid_q <= enPipe_q[RD_LAT-1];
      if (enPipe_q[RD_LAT-1]) begin
        dout_q <= RamData_i;
      end
    end
  end

  assign RamAddr_o   = ramAddr_q;
  assign RamEn_o     = ramEn_q;
  assign Dout_o      = dout_q;
  assign DoutValid_o = doutValid_q;
  assign Busy_o      = busy_q;
  assign Wrap_o      = wrap_q;

endmodule

// File: tb/tb_triaram_reader.sv
// Self-checking bench for triaram_reader: playback-level reference model plus directed literal checks.
// Honours TRIARAM_RD_MIRROR_EN so the same bench covers both builds.
module tb_triaram_reader;

  localparam int AW     = 10;
  localparam int DW     = 16;
  localparam int PW     = 32;
  localparam int RD_LAT = 2;

`ifdef TRIARAM_RD_MIRROR_EN
  localparam logic [PW-1:0] TUNE_STEP = 32'h0020_0000;
  localparam int            PERIOD    = 2048;
  localparam logic [AW-1:0] HALF_ADDR = 10'd1023;
`else
  localparam logic [PW-1:0] TUNE_STEP = 32'h0040_0000;
  localparam int            PERIOD    = 1024;
  localparam logic [AW-1:0] HALF_ADDR = 10'd512;
`endif

  logic          clock = 1'b0;
  logic          reset_n = 1'b1;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [PW-1:0] tuning = '0;
  logic [AW-1:0] ramAddr;
  logic          ramEn;
  logic [DW-1:0] ramData;
  logic [DW-1:0] dout;
  logic          doutValid;
  logic          busy;
  logic          wrap;

  triaram_reader #(.AW(AW), .DW(DW), .PW(PW), .RD_LAT(RD_LAT)) dut (
    .Clock_i(clock), .Reset_n_i(reset_n), .Start_i(start), .Stop_i(stop),
    .Tuning_i(tuning), .RamAddr_o(ramAddr), .RamEn_o(ramEn), .RamData_i(ramData),
    .Dout_o(dout), .DoutValid_o(doutValid), .Busy_o(busy), .Wrap_o(wrap)
  );

  always #5 clock = ~clock;

  // RAM stand-in: word = 3*address, returned RD_LAT clocks after the address is sampled.
  logic [DW-1:0] ramPipe [RD_LAT];
  always @(posedge clock) begin
    ramPipe[0] <= DW'(3 * ramAddr);
    for (int i = 1; i < RD_LAT; i++) ramPipe[i] <= ramPipe[i-1];
  end
  assign ramData = ramPipe[RD_LAT-1];

  int nVectors = 0;
  int nFail = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nVectors++;
    if (actual !== expected) begin
      nFail++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [AW-1:0] addrOf(input logic [PW-1:0] ph);
    longint pos;
`ifdef TRIARAM_RD_MIRROR_EN
    pos = (longint'(ph) >> (PW - AW - 1)) % (longint'(1) << AW);
    if (longint'(ph) >= (longint'(1) << (PW - 1))) pos = (longint'(1) << AW) - 1 - pos;
`else
    pos = longint'(ph) >> (PW - AW);
`endif
    return AW'(pos);
  endfunction

  typedef struct { int due; logic [DW-1:0] data; } sample_t;
  sample_t expQ[$];

  bit            mRunning;
  int            mEdge, mDrainUntil;
  logic [PW-1:0] mPhase;
  logic [AW-1:0] mAddr;
  logic          mEn, mWrap, mBusy, mDvalid;
  logic [DW-1:0] mDout;

  task automatic modelReset();
    mRunning = 0; mEdge = 0; mDrainUntil = -1; mPhase = '0;
    mAddr = '0; mEn = 0; mWrap = 0; mBusy = 0; mDvalid = 0; mDout = '0;
    expQ.delete();
  endtask

  // Playback view: reads issued while running, each returning as a sample RD_LAT+1 edges later.
  task automatic modelStep(input logic st, input logic sp, input logic [PW-1:0] tu);
    longint s;
    mEdge++;
    mEn = 0;
    mWrap = 0;
    if (mRunning) begin
      if (sp) begin
        mRunning = 0;
        mDrainUntil = mEdge + RD_LAT;
      end else begin
        mEn = 1;
        mAddr = addrOf(mPhase);
        expQ.push_back('{mEdge + RD_LAT + 1, DW'(3 * mAddr)});
        if (st) mPhase = '0;
        else begin
          s = longint'(mPhase) + longint'(tu);
          mWrap = (s >= (longint'(1) << PW));
          mPhase = PW'(s);
        end
      end
    end else if (mEdge > mDrainUntil && st && !sp) begin
      mRunning = 1;
      mPhase = '0;
    end
    mBusy = mRunning || (mEdge < mDrainUntil);
    if (expQ.size() > 0 && expQ[0].due == mEdge) begin
      mDvalid = 1;
      mDout = expQ[0].data;
      void'(expQ.pop_front());
    end else mDvalid = 0;
  endtask

  initial modelReset();

  always @(posedge clock) begin
    logic sSt, sSp, sRst;
    logic [PW-1:0] sTu;
    sSt = start; sSp = stop; sTu = tuning; sRst = reset_n;
    #1;
    if (!sRst) modelReset();
    else modelStep(sSt, sSp, sTu);
    checkOutput("RamEn", ramEn, mEn);
    checkOutput("RamAddr", ramAddr, mAddr);
    checkOutput("Wrap", wrap, mWrap);
    checkOutput("Busy", busy, mBusy);
    checkOutput("DoutValid", doutValid, mDvalid);
    checkOutput("Dout", dout, mDout);
  end

  task automatic applyStimulus(input logic st, input logic sp, input logic [PW-1:0] tu);
    @(negedge clock);
    start = st; stop = sp; tuning = tu;
    @(posedge clock);
    #2;
  endtask

  int enCnt, dvCnt, wrapCnt;
  logic [AW-1:0] altAddr [4];
  logic          altWrap [4];

  initial begin
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    checkOutput("reset RamEn", ramEn, 0);
    checkOutput("reset Busy", busy, 0);
    checkOutput("reset DoutValid", doutValid, 0);
    checkOutput("reset Dout", dout, 0);

    // Basic stream, then stop at edge 21 after start at edge 0.
    enCnt = 0; dvCnt = 0;
    applyStimulus(1, 0, TUNE_STEP);
    checkOutput("start Busy", busy, 1);
    checkOutput("start RamEn", ramEn, 0);
    for (int k = 1; k <= 20; k++) begin
      applyStimulus(0, 0, TUNE_STEP);
      enCnt += int'(ramEn); dvCnt += int'(doutValid);
      if (k <= 3) checkOutput("first addrs", ramAddr, k - 1);
      if (k == 3) checkOutput("no early valid", doutValid, 0);
      if (k >= 4 && k <= 6) checkOutput("first samples", {doutValid, dout}, {1'b1, DW'(3 * (k - 4))});
    end
    applyStimulus(0, 1, TUNE_STEP);
    enCnt += int'(ramEn); dvCnt += int'(doutValid);
    checkOutput("stop RamEn", ramEn, 0);
    applyStimulus(0, 0, TUNE_STEP);
    dvCnt += int'(doutValid);
    checkOutput("drain Busy", busy, 1);
    applyStimulus(0, 0, TUNE_STEP);
    dvCnt += int'(doutValid);
    checkOutput("busy drop", busy, 0);
    checkOutput("last sample", dout, 57);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 0, TUNE_STEP);
      enCnt += int'(ramEn); dvCnt += int'(doutValid);
    end
    checkOutput("RamEn count", enCnt, 20);
    checkOutput("DoutValid count", dvCnt, 20);

    // Half-scale tuning alternates between two table positions and wraps every other cycle.
    altAddr = '{10'd0, HALF_ADDR, 10'd0, HALF_ADDR};
    altWrap = '{1'b0, 1'b1, 1'b0, 1'b1};
    applyStimulus(1, 0, 32'h8000_0000);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(0, 0, 32'h8000_0000);
      checkOutput("half addr", ramAddr, altAddr[k]);
      checkOutput("half wrap", wrap, altWrap[k]);
    end
    applyStimulus(1, 0, '0);
    for (int k = 0; k < 6; k++) begin
      applyStimulus(0, 0, '0);
      checkOutput("zero tune addr", ramAddr, 0);
      if (k >= 2) checkOutput("zero tune valid", doutValid, 1);
    end
    applyStimulus(0, 1, '0);
    repeat (4) applyStimulus(0, 0, '0);

    // Simultaneous start and stop from idle does nothing.
    applyStimulus(1, 1, TUNE_STEP);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(0, 0, TUNE_STEP);
      checkOutput("start+stop Busy", busy, 0);
      checkOutput("start+stop RamEn", ramEn, 0);
    end

    // Restart while running: address jumps to 0 with no gap in the sample stream.
    applyStimulus(1, 0, TUNE_STEP);
    repeat (8) applyStimulus(0, 0, TUNE_STEP);
    applyStimulus(1, 0, TUNE_STEP);
    checkOutput("pre-restart addr", ramAddr, 8);
    for (int k = 0; k < 6; k++) begin
      applyStimulus(0, 0, TUNE_STEP);
      if (k == 0) checkOutput("restart addr", ramAddr, 0);
      checkOutput("restart no gap", doutValid, 1);
    end

    // Asynchronous reset between edges while streaming.
    @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("async RamEn", ramEn, 0);
    checkOutput("async DoutValid", doutValid, 0);
    checkOutput("async Busy", busy, 0);
    checkOutput("async Dout", dout, 0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(0, 0, TUNE_STEP);
      checkOutput("no stale valid", doutValid, 0);
    end

    // Two full periods of the nominal tuning word give exactly two wraps.
    wrapCnt = 0;
    applyStimulus(1, 0, TUNE_STEP);
    for (int k = 0; k < 2 * PERIOD; k++) begin
      applyStimulus(0, 0, TUNE_STEP);
      wrapCnt += int'(wrap);
    end
    checkOutput("wrap count", wrapCnt, 2);
    applyStimulus(0, 1, TUNE_STEP);
    repeat (4) applyStimulus(0, 0, TUNE_STEP);

    // Randomised control and tuning, checked every cycle by the model.
    for (int i = 0; i < 800; i++) begin
      logic [PW-1:0] tu;
      case ($urandom_range(0, 3))
        0: tu = $urandom;
        1: tu = TUNE_STEP;
        2: tu = '0;
        default: tu = 32'h8000_0000 + PW'($urandom_range(0, 255));
      endcase
      if (i == 400) begin
        @(negedge clock);
        #3 reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
      end
      applyStimulus($urandom_range(0, 15) == 0, $urandom_range(0, 29) == 0, tu);
    end
    applyStimulus(0, 1, '0);
    repeat (5) applyStimulus(0, 0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nFail);
    $finish;
  end

endmodule
